hazard_fwd_scoreboard: RTL

Parametrised successor to the pipeline forwarding logic, combining operand forwarding, load-use stall detection and a register scoreboard for long-latency ops (mul/div) that write back out of order. It sits between ID/EX control and the pipeline registers. It drives forwarding mux selects for the EX operands and a stall/bubble request for IF/ID. A FWD_EN mode converts all RAW hazards to stalls when forwarding is disabled. A saturating stall-cycle counter is kept for performance visibility.

---
 rtl/hazard_fwd_scoreboard_if.sv | 49 ++++
 rtl/hazard_fwd_scoreboard.sv | 134 +++++++++++++
 2 files changed

// File: rtl/hazard_fwd_scoreboard_if.sv
// Hazard/forwarding bundle between pipeline control and hazard_fwd_scoreboard.
//   master : pipeline control side (drives ID/EX/MEM/WB and long-op status,
//            receives forwarding selects, stall, scoreboard status, stall count)
//   slave  : hazard_fwd_scoreboard side
// Signal names follow the original flat port list.
interface hazard_fwd_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_lop;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [REG_ADDR_W-1:0] id_ex_rs1;
  logic [REG_ADDR_W-1:0] id_ex_rs2;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic                  id_ex_reg_write;
  logic                  id_ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_mem_rd;
  logic                  ex_mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_wb_rd;
  logic                  mem_wb_reg_write;
  logic                  lop_issue;
  logic [REG_ADDR_W-1:0] lop_rd;
  logic                  lop_wb_valid;
  logic [REG_ADDR_W-1:0] lop_wb_rd;
  logic [1:0]            forward_a;
  logic [1:0]            forward_b;
  logic                  stall;
  logic                  sb_busy;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_lop, id_rd,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
           ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write,
           lop_issue, lop_rd, lop_wb_valid, lop_wb_rd,
    input  forward_a, forward_b, stall, sb_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_lop, id_rd,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
           ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write,
           lop_issue, lop_rd, lop_wb_valid, lop_wb_rd,
    output forward_a, forward_b, stall, sb_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_scoreboard.sv
// Operand forwarding, load-use / scoreboard / WAW stall detection and a
// pending-write scoreboard for out-of-order long-latency writebacks.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears scoreboard and stall count)
//   bus  - hazard_fwd_scoreboard_if.slave: pipeline register fields in,
//          forward_a/forward_b (00 regfile, 10 EX/MEM, 01 MEM/WB,
//          11 long-op writeback), stall, sb_busy, stall_cnt out
// Parameters: REG_ADDR_W register address width, FWD_EN forwarding enable
// (0 turns every RAW hazard into a stall), CNT_W stall counter width.
// The interface instance must be built with the same REG_ADDR_W and CNT_W.
module hazard_fwd_scoreboard #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard_fwd_scoreboard_if.slave bus
);
  localparam int unsigned NREG = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] addr_t;

  logic [NREG-1:0]  sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  function automatic logic [1:0] fwd_sel(
    input addr_t rs,
    input logic  em_we, input addr_t em_rd,
    input logic  mw_we, input addr_t mw_rd,
    input logic  lw_v,  input addr_t lw_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (em_we && em_rd != '0 && em_rd == rs)      sel = 2'b10;
    else if (mw_we && mw_rd != '0 && mw_rd == rs) sel = 2'b01;
    else if (lw_v && lw_rd != '0 && lw_rd == rs)  sel = 2'b11;
    return sel;
  endfunction

  // Register pending and not being written back this very cycle.
  function automatic logic sb_pending(
    input logic [NREG-1:0] sb,
    input addr_t           r,
    input logic            lw_v,
    input addr_t           lw_rd
  );
    return (r != '0) && sb[r] && !(lw_v && lw_rd == r);
  endfunction

  // Any in-flight producer in EX/MEM/WB writing this source register.
  function automatic logic pipe_raw(
    input addr_t rs,
    input logic  ex_we, input addr_t ex_rd,
    input logic  em_we, input addr_t em_rd,
    input logic  mw_we, input addr_t mw_rd
  );
    return (rs != '0) && ((ex_we && ex_rd == rs) ||
                          (em_we && em_rd == rs) ||
                          (mw_we && mw_rd == rs));
  endfunction

  // Forwarding selects
  always_comb begin
    bus.forward_a = 2'b00;
    bus.forward_b = 2'b00;
    if (FWD_EN) begin
      bus.forward_a = fwd_sel(bus.id_ex_rs1,
                              bus.ex_mem_reg_write, bus.ex_mem_rd,
                              bus.mem_wb_reg_write, bus.mem_wb_rd,
                              bus.lop_wb_valid,     bus.lop_wb_rd);
      bus.forward_b = fwd_sel(bus.id_ex_rs2,
                              bus.ex_mem_reg_write, bus.ex_mem_rd,
                              bus.mem_wb_reg_write, bus.mem_wb_rd,
                              bus.lop_wb_valid,     bus.lop_wb_rd);
    end
  end

  // Stall request
  always_comb begin
    logic sb_raw, waw, load_use, nofwd_raw;
    sb_raw    = sb_pending(sb_q, bus.id_rs1, bus.lop_wb_valid, bus.lop_wb_rd) ||
                sb_pending(sb_q, bus.id_rs2, bus.lop_wb_valid, bus.lop_wb_rd);
    waw       = bus.id_lop &&
                sb_pending(sb_q, bus.id_rd, bus.lop_wb_valid, bus.lop_wb_rd);
    load_use  = bus.id_ex_mem_read && (bus.id_ex_rd != '0) &&
                ((bus.id_ex_rd == bus.id_rs1) || (bus.id_ex_rd == bus.id_rs2));
    nofwd_raw = 1'b0;
    if (!FWD_EN) begin
      nofwd_raw = pipe_raw(bus.id_rs1,
                           bus.id_ex_reg_write,  bus.id_ex_rd,
                           bus.ex_mem_reg_write, bus.ex_mem_rd,
                           bus.mem_wb_reg_write, bus.mem_wb_rd) ||
                  pipe_raw(bus.id_rs2,
                           bus.id_ex_reg_write,  bus.id_ex_rd,
                           bus.ex_mem_reg_write, bus.ex_mem_rd,
                           bus.mem_wb_reg_write, bus.mem_wb_rd);
    end
    stall = bus.id_valid && (sb_raw || waw || load_use || nofwd_raw);
  end

  // Scoreboard next state: clear first so a same-cycle issue to the same
  // register leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (bus.lop_wb_valid)
      sb_d[bus.lop_wb_rd] = 1'b0;
    if (bus.lop_issue && bus.lop_rd != '0)
      sb_d[bus.lop_rd] = 1'b1;
  end

  // Saturating stall counter
  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.sb_busy   = |sb_q;
  assign bus.stall_cnt = cnt_q;
endmodule
